// File: rtl/note_delay_line.sv
// note_delay_line: tick-paced per-channel note delay line with a combinational tap.
// Define NOTE_ONSET_EN to build per-channel onset pulse logic; otherwise onset is tied to 0.
module note_delay_line #(
  parameter int NUM_CH = 8,
  parameter int DEPTH = 64,
  parameter int PERIOD = 100000,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(PERIOD),
  localparam int FW = AW + 1
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [NUM_CH-1:0] in_notes,
  input  logic [1:0]        in_shift,
  output logic              in_ready,
  input  logic              pause,
  input  logic [AW-1:0]     delay,
  output logic [NUM_CH-1:0] out_notes,
  output logic [1:0]        out_shift,
  output logic              tick,
  output logic              primed,
  output logic [NUM_CH-1:0] onset
);
  logic [CW-1:0] cnt;
  logic [FW-1:0] fill;
  logic [NUM_CH-1:0] note_line [DEPTH];
  logic [1:0] shift_line [DEPTH];
  // rst_n gates tick so reset silences it without waiting for the counter
  assign tick = rst_n && !pause && cnt == CW'(PERIOD - 1);
  assign in_ready = tick;
  assign primed = fill > {1'b0, delay};
  assign out_notes = primed ? note_line[delay] : '0;
  assign out_shift = primed ? shift_line[delay] : '0;
  always_ff @(posedge vga_clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (!pause) cnt <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + 1'b1;
  always_ff @(posedge vga_clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        note_line[i] <= '0;
        shift_line[i] <= '0;
      end
      fill <= '0;
    end else if (tick) begin
      note_line[0] <= in_valid ? in_notes : '0;
      shift_line[0] <= in_valid ? in_shift : '0;
      for (int i = 1; i < DEPTH; i++) begin
        note_line[i] <= note_line[i-1];
        shift_line[i] <= shift_line[i-1];
      end
      if (fill != FW'(DEPTH)) fill <= fill + 1'b1;
    end
`ifdef NOTE_ONSET_EN
  logic tick_d;
  logic [NUM_CH-1:0] prev_out;
  // prev_out holds the tap as it was just before the shift
  always_ff @(posedge vga_clk or negedge rst_n)
    if (!rst_n) begin
      tick_d <= 1'b0;
      prev_out <= '0;
    end else begin
      tick_d <= tick;
      if (tick) prev_out <= out_notes;
    end
  assign onset = tick_d ? out_notes & ~prev_out : '0;
`else
  assign onset = '0;
`endif
endmodule

// File: tb/tb_note_delay_line.sv
// tb_note_delay_line: directed stimulus feeding a scoreboard of point checks and note events.
module tb_note_delay_line;
  logic vga_clk = 0, rst_n, in_valid, pause, in_ready, tick, primed;
  logic [7:0] in_notes, out_notes, onset;
  logic [1:0] in_shift, out_shift;
  logic [2:0] delay;
  int cyc, checks = 0, failures = 0;
  logic done;
`ifdef NOTE_ONSET_EN
  localparam bit ONS = 1;
`else
  localparam bit ONS = 0;
`endif
  localparam int S_TICK = 0, S_RDY = 1, S_PRIM = 2, S_NOTES = 3, S_SHIFT = 4, S_ONS = 5;
  typedef struct packed { logic [2:0] sel; logic [7:0] exp; } pt_t;
  typedef struct packed { logic [7:0] notes; logic [1:0] shift; logic [15:0] start; logic [15:0] len; } ev_t;
  pt_t pq[$];
  ev_t eq[$];

  note_delay_line #(.NUM_CH(8), .DEPTH(8), .PERIOD(4)) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .in_valid(in_valid), .in_notes(in_notes),
    .in_shift(in_shift), .in_ready(in_ready), .pause(pause), .delay(delay),
    .out_notes(out_notes), .out_shift(out_shift), .tick(tick), .primed(primed), .onset(onset)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic string sname(logic [2:0] s);
    return s == 0 ? "tick" : s == 1 ? "in_ready" : s == 2 ? "primed" :
           s == 3 ? "out_notes" : s == 4 ? "out_shift" : "onset";
  endfunction

  function automatic int sval(logic [2:0] s);
    return s == 0 ? int'(tick) : s == 1 ? int'(in_ready) : s == 2 ? int'(primed) :
           s == 3 ? int'(out_notes) : s == 4 ? int'(out_shift) : int'(onset);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic pc(int s, int e);
    pq.push_back({3'(s), 8'(e)});
  endtask

  task automatic go(int n);
    while (cyc < n) begin
      @(posedge vga_clk);
      #1;
      cyc++;
    end
  endtask

  // monitor: pops point checks every cycle and tracks note events on out_notes
  initial begin
    pt_t p;
    ev_t ev;
    logic open_ev;
    logic [7:0] prev_notes;
    open_ev = 0;
    prev_notes = 0;
    forever begin
      @(negedge vga_clk);
      while (pq.size() > 0) begin
        p = pq.pop_front();
        check(sname(p.sel), sval(p.sel), int'(p.exp));
      end
      if (out_notes != prev_notes) begin
        if (open_ev) begin
          check("ev_len", cyc - int'(ev.start), int'(ev.len));
          open_ev = 0;
        end
        if (out_notes != 0) begin
          if (eq.size() == 0) check("unexpected_notes", int'(out_notes), 0);
          else begin
            ev = eq.pop_front();
            open_ev = 1;
            check("ev_notes", int'(out_notes), int'(ev.notes));
            check("ev_start", cyc, int'(ev.start));
          end
        end
      end
      check(open_ev ? "ev_shift" : "idle_shift", int'(out_shift), open_ev ? int'(ev.shift) : 0);
      prev_notes = out_notes;
      if (done) begin
        check("leftover_events", eq.size() + int'(open_ev), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    rst_n = 0; in_valid = 0; in_notes = 0; in_shift = 0; pause = 0; delay = 0; done = 0; cyc = 0;
    repeat (2) @(posedge vga_clk);
    #1;
    for (int s = 0; s < 6; s++) pc(s, 0);
    @(posedge vga_clk);
    #1;
    rst_n = 1;
    for (int c = 0; c < 12; c++) begin
      go(c);
      pc(S_TICK, c % 4 == 3);
      pc(S_RDY, c % 4 == 3);
      if (c == 3) pc(S_PRIM, 0);
      if (c == 4) pc(S_PRIM, 1);
    end
    // D=5 with a 10-cycle pause: output moves from cycle 36 to 46
    go(12); delay = 5; in_valid = 1; in_notes = 8'h0A; in_shift = 2'b01;
    eq.push_back({8'h0A, 2'b01, 16'd46, 16'd4});
    go(16); in_valid = 0; in_notes = 0; in_shift = 0;
    go(24); pause = 1;
    for (int c = 24; c < 34; c++) begin
      go(c);
      pc(S_TICK, 0);
    end
    go(34); pause = 0;
    go(36); pc(S_TICK, 0);
    go(37); pc(S_TICK, 1); pc(S_RDY, 1);
    // D=3 single note, then shifted note
    go(50); delay = 3; in_valid = 1; in_notes = 8'h05;
    eq.push_back({8'h05, 2'b00, 16'd66, 16'd4});
    go(54); in_valid = 0; in_notes = 0;
    go(58); in_valid = 1; in_notes = 8'h80; in_shift = 2'b10;
    eq.push_back({8'h80, 2'b10, 16'd74, 16'd4});
    go(62); in_valid = 0; in_notes = 0; in_shift = 0;
    go(66); pc(S_ONS, ONS ? 8'h05 : 0);
    go(67); pc(S_ONS, 0);
    go(74); pc(S_ONS, ONS ? 8'h80 : 0); pc(S_SHIFT, 2);
    // D=7 then switch to 2 after four ticks
    go(94); delay = 7; in_valid = 1; in_notes = 8'h11;
    eq.push_back({8'h22, 2'b00, 16'd110, 16'd4});
    eq.push_back({8'h33, 2'b00, 16'd114, 16'd4});
    eq.push_back({8'h44, 2'b00, 16'd118, 16'd4});
    go(98); in_notes = 8'h22;
    go(102); in_notes = 8'h33;
    go(106); in_notes = 8'h44;
    go(109); pc(S_PRIM, 1); pc(S_NOTES, 0);
    go(110); delay = 2; in_valid = 0; in_notes = 0; pc(S_PRIM, 1); pc(S_NOTES, 8'h22);
    // channel 0 held for three ticks at D=0
    go(122); delay = 0; in_valid = 1; in_notes = 8'h01;
    eq.push_back({8'h01, 2'b00, 16'd126, 16'd12});
    go(126); pc(S_ONS, ONS ? 1 : 0);
    go(127); pc(S_ONS, 0);
    go(130); pc(S_ONS, 0);
    go(134); in_valid = 0; in_notes = 0; pc(S_ONS, 0);
    // reset during a consuming tick
    go(141); in_valid = 1; in_notes = 8'hFF; pc(S_TICK, 1); pc(S_RDY, 1);
    @(negedge vga_clk);
    #1;
    rst_n = 0;
    for (int s = 0; s < 6; s++) pc(s, 0);
    repeat (2) @(posedge vga_clk);
    #1;
    rst_n = 1; cyc = 0; in_valid = 0; in_notes = 0;
    for (int c = 0; c < 6; c++) begin
      go(c);
      pc(S_TICK, c == 3);
      if (c == 4) begin
        pc(S_PRIM, 1);
        pc(S_NOTES, 0);
      end
    end
    go(8);
    done = 1;
  end
endmodule
